// File: rtl/winner_pkg.sv
// rtl/winner_pkg.sv - shared FSM state and per-punter result encoding
package winner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_EVAL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RES_LOSE = 2'd0,
    RES_WIN  = 2'd1,
    RES_PUSH = 2'd2
  } result_t;

endpackage

// File: rtl/hand_compare.sv
// rtl/hand_compare.sv - combinational resolution of one punter against the dealer
module hand_compare
  import winner_pkg::*;
#(
  parameter int VAL_W    = 5,
  parameter int TIE_PUSH = 1
) (
  input  logic [VAL_W-1:0] punter_total,
  input  logic             punter_bust,
  input  logic [VAL_W-1:0] dealer_total,
  input  logic             dealer_bust,
  output logic [1:0]       result
);

  result_t res;

  // A busted punter loses even when the dealer also busted.
  always_comb begin
    res = RES_LOSE;
    if (punter_bust)
      res = RES_LOSE;
    else if (dealer_bust)
      res = RES_WIN;
    else if (punter_total > dealer_total)
      res = RES_WIN;
    else if (punter_total == dealer_total)
      res = (TIE_PUSH != 0) ? RES_PUSH : RES_LOSE;
  end

  assign result = res;

endmodule

// File: rtl/multi_winner_calc.sv
// rtl/multi_winner_calc.sv - dealer plus N punters round sequencer and result register
module multi_winner_calc
  import winner_pkg::*;
#(
  parameter int  NUM_PUNTERS = 4,
  parameter int  VAL_W       = 5,
  parameter int  BUST_LIMIT  = 21,
  parameter int  TIE_PUSH    = 1,
  localparam int IDX_W       = $clog2(NUM_PUNTERS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   game_on,
  input  logic [VAL_W-1:0]       total_value,
  input  logic                   hold,
  input  logic                   bust,
  output logic [IDX_W-1:0]       player,
  output logic                   dealer_turn,
  output logic [NUM_PUNTERS-1:0] win,
  output logic [NUM_PUNTERS-1:0] push,
  output logic                   winstrobe,
  output logic                   busy
);

  localparam logic [IDX_W-1:0] LAST_SEAT  = IDX_W'(NUM_PUNTERS);
  localparam logic [31:0]      BUST_LIM_U = BUST_LIMIT;

  state_t                 state;
  logic [VAL_W-1:0]       slot_total [NUM_PUNTERS+1];
  logic [NUM_PUNTERS:0]   slot_bust;
  logic [NUM_PUNTERS-1:0] win_next;
  logic [NUM_PUNTERS-1:0] push_next;
  logic [31:0]            total_ext;
  logic                   seat_event;
  logic                   event_bust;

  // Widen before comparing so a limit at or above 2**VAL_W never wraps.
  assign total_ext  = 32'(total_value);
  assign event_bust = bust | (total_ext > BUST_LIM_U);
  assign seat_event = game_on & (hold | bust);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      player      <= '0;
      dealer_turn <= 1'b0;
      win         <= '0;
      push        <= '0;
      winstrobe   <= 1'b0;
      busy        <= 1'b0;
      slot_bust   <= '0;
      for (int i = 0; i <= NUM_PUNTERS; i++) slot_total[i] <= '0;
    end else begin
      winstrobe <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (game_on) begin
            state       <= ST_PLAY;
            player      <= '0;
            dealer_turn <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (seat_event) begin
            slot_total[player] <= total_value;
            slot_bust[player]  <= event_bust;
            dealer_turn        <= 1'b0;
            if (player != LAST_SEAT)
              player <= player + 1'b1;
            else
              state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          win       <= win_next;
          push      <= push_next;
          winstrobe <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // game_on must drop before another round can start.
          if (!game_on) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 1; g <= NUM_PUNTERS; g++) begin : g_seat
    logic [1:0] res;

    hand_compare #(
      .VAL_W    (VAL_W),
      .TIE_PUSH (TIE_PUSH)
    ) u_cmp (
      .punter_total (slot_total[g]),
      .punter_bust  (slot_bust[g]),
      .dealer_total (slot_total[0]),
      .dealer_bust  (slot_bust[0]),
      .result       (res)
    );

    assign win_next[g-1]  = (res == RES_WIN);
    assign push_next[g-1] = (res == RES_PUSH);
  end

endmodule

// File: tb/tb_multi_winner_calc.sv
// tb/tb_multi_winner_calc.sv - directed and random rounds against a behavioural blackjack model
module tb_multi_winner_calc;

  localparam int NP = 4;
  localparam int VW = 5;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          game_on = 1'b0;
  logic          hold = 1'b0;
  logic          bust = 1'b0;
  logic [VW-1:0] total_value = '0;

  logic [IW-1:0] player, player0;
  logic          dealer_turn, dealer_turn0;
  logic [NP-1:0] win, push, win0, push0;
  logic          winstrobe, winstrobe0, busy, busy0;

  multi_winner_calc #(.NUM_PUNTERS(NP), .VAL_W(VW), .BUST_LIMIT(21), .TIE_PUSH(1)) dut (
    .clock(clock), .reset(reset), .game_on(game_on), .total_value(total_value),
    .hold(hold), .bust(bust), .player(player), .dealer_turn(dealer_turn),
    .win(win), .push(push), .winstrobe(winstrobe), .busy(busy)
  );

  multi_winner_calc #(.NUM_PUNTERS(NP), .VAL_W(VW), .BUST_LIMIT(21), .TIE_PUSH(0)) dut0 (
    .clock(clock), .reset(reset), .game_on(game_on), .total_value(total_value),
    .hold(hold), .bust(bust), .player(player0), .dealer_turn(dealer_turn0),
    .win(win0), .push(push0), .winstrobe(winstrobe0), .busy(busy0)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int strobes = 0;
  int rounds = 0;

  // Seat 0 is the dealer; how: 0 = hold, 1 = bust, 2 = hold and bust together.
  int tot [NP+1];
  int how [NP+1];
  logic [NP-1:0] last_win, last_push, last_win0, last_push0;

  always @(negedge clock) if (winstrobe) strobes++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Returns {push, win} from the card rules.
  function automatic logic [2*NP-1:0] model(input bit tie);
    logic [NP-1:0] w = '0;
    logic [NP-1:0] p = '0;
    bit dealer_out = (how[0] != 0) || (tot[0] > 21);
    for (int i = 1; i <= NP; i++) begin
      bit punter_out = (how[i] != 0) || (tot[i] > 21);
      if (punter_out) continue;
      if (dealer_out || tot[i] > tot[0]) w[i-1] = 1'b1;
      else if (tot[i] == tot[0] && tie) p[i-1] = 1'b1;
    end
    return {p, w};
  endfunction

  task automatic set_round(input int t0, h0, t1, h1, t2, h2, t3, h3, t4, h4);
    tot[0] = t0; how[0] = h0; tot[1] = t1; how[1] = h1; tot[2] = t2; how[2] = h2;
    tot[3] = t3; how[3] = h3; tot[4] = t4; how[4] = h4;
  endtask

  task automatic play(input bit pause_mid);
    logic [2*NP-1:0] e1, e0;
    game_on = 1'b1;
    step();
    chk("busy_play", busy, 1);
    for (int s = 0; s <= NP; s++) begin
      chk("player", player, s);
      chk("dealer_turn", dealer_turn, (s == 0));
      chk("win_held", win, last_win);
      if (pause_mid && s == 2) begin
        game_on = 1'b0;
        hold = 1'b1;
        total_value = 5'd31;
        repeat (3) begin
          step();
          chk("pause_player", player, 2);
          chk("pause_busy", busy, 1);
        end
        hold = 1'b0;
        game_on = 1'b1;
      end
      total_value = VW'(tot[s]);
      hold = (how[s] != 1);
      bust = (how[s] != 0);
      step();
      hold = 1'b0;
      bust = 1'b0;
    end
    chk("eval_strobe", winstrobe, 0);
    chk("eval_busy", busy, 1);
    chk("eval_win_held", win, last_win);
    chk("eval_push_held", push, last_push);
    step();
    e1 = model(1'b1);
    e0 = model(1'b0);
    chk("strobe", winstrobe, 1);
    chk("win", win, e1[NP-1:0]);
    chk("push", push, e1[2*NP-1:NP]);
    chk("win_tie0", win0, e0[NP-1:0]);
    chk("push_tie0", push0, e0[2*NP-1:NP]);
    chk("done_busy", busy, 0);
    step();
    chk("strobe_drop", winstrobe, 0);
    chk("win_after", win, e1[NP-1:0]);
    game_on = 1'b0;
    step();
    rounds++;
    last_win = e1[NP-1:0];
    last_push = e1[2*NP-1:NP];
    last_win0 = e0[NP-1:0];
    last_push0 = e0[2*NP-1:NP];
  endtask

  initial begin
    last_win = '0; last_push = '0; last_win0 = '0; last_push0 = '0;
    repeat (2) step();
    chk("rst_player", player, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win", win, 0);
    chk("rst_push", push, 0);
    chk("rst_strobe", winstrobe, 0);
    chk("rst_dealer", dealer_turn, 0);
    reset = 1'b1;
    step();

    set_round(18, 0, 20, 0, 18, 0, 17, 0, 25, 1);
    play(1'b0);
    chk("r031_win", win, 4'b0001);
    chk("r031_push", push, 4'b0010);

    set_round(23, 1, 12, 0, 21, 0, 22, 1, 15, 0);
    play(1'b0);
    chk("r032_win", win, 4'b1011);
    chk("r032_push", push, 4'b0000);

    set_round(19, 0, 19, 0, 19, 0, 19, 0, 19, 0);
    play(1'b0);
    chk("r033_push", push, 4'b1111);
    chk("r033_win0", win0, 4'b0000);
    chk("r033_push0", push0, 4'b0000);

    set_round(15, 0, 20, 2, 22, 0, 16, 0, 10, 0);
    play(1'b0);
    chk("r034_win", win, 4'b0100);

    set_round(17, 0, 19, 0, 17, 0, 21, 0, 14, 0);
    play(1'b1);

    for (int r = 0; r < 10; r++) begin
      for (int s = 0; s <= NP; s++) begin
        int k = $urandom_range(9, 0);
        tot[s] = (k == 0) ? $urandom_range(31, 0) : $urandom_range(24, 14);
        k = $urandom_range(9, 0);
        how[s] = (k < 7) ? 0 : (k < 9) ? 1 : 2;
      end
      play(1'b0);
    end

    // Asynchronous reset in the middle of a round.
    set_round(18, 0, 20, 0, 18, 0, 17, 0, 25, 1);
    play(1'b0);
    game_on = 1'b1;
    step();
    total_value = 5'd18;
    hold = 1'b1;
    step();
    hold = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_player", player, 0);
    chk("arst_dealer", dealer_turn, 0);
    chk("arst_win", win, 0);
    chk("arst_push", push, 0);
    chk("arst_strobe", winstrobe, 0);
    chk("arst_busy", busy, 0);
    chk("arst_win0", win0, 0);
    game_on = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_rst_busy", busy, 0);
    last_win = '0; last_push = '0; last_win0 = '0; last_push0 = '0;

    set_round(20, 0, 21, 0, 20, 0, 19, 0, 30, 0);
    play(1'b0);

    chk("strobe_count", strobes, rounds);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
